micro_sequencer: RTL and testbench
==================================

# micro_sequencer

- Consumes the 5-bit first-microinstruction address produced by the opcode map stage.
- Owns the microprogram counter (uPC) that indexes the control-store ROM.
- Applies the ROM's next-address control each cycle: increment, dispatch, jump, conditional jump, fetch and optional call/return.
- Issues the IR load strobe, counts dispatched instructions, and traps illegal sequencing with a sticky fault.

## Interface
Parameters:
- UPC_W, 5, microaddress width; must match the map stage output width.
- CNT_W, 16, dispatch counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- map_addr  in  UPC_W  mapped start address from the opcode map stage.
- next_sel  in  3  next-address select, from the ROM word at the current uPC.
- branch_addr  in  UPC_W  jump/call target, from the ROM word.
- z_flag  in  1  datapath zero flag.
- stall  in  1  freezes all sequencer state for the cycle.
- upc  out  UPC_W  current microaddress to the control-store ROM.
- ir_load  out  1  IR capture strobe.
- fault  out  1  sticky sequencing error.
- dispatch_cnt  out  CNT_W  number of successful dispatches.

## Operation
Reset values:
- upc = 0, fault = 0, dispatch_cnt = 0, return stack empty.
- ir_load = 1 in the first cycle after reset release.

ir_load:
- Combinational: ir_load = (upc == 0) && !stall && !fault.
- Word 0 is the fetch microinstruction; word 1 is reserved for the fetch/decode wait.

next_sel encodings, applied at each rising edge when !stall && !fault:
- 000 INC: upc ← upc+1, modulo 2^UPC_W (31 wraps to 0).
- 001 DISPATCH: if map_addr ≥ 2, upc ← map_addr and dispatch_cnt increments (wraps at all-ones). If map_addr < 2, fault ← 1 and upc ← 0.
- 010 JUMP: upc ← branch_addr.
- 011 JZ: upc ← z_flag ? branch_addr : upc+1.
- 100 JNZ: upc ← z_flag ? upc+1 : branch_addr.
- 101 FETCH: upc ← 0 (end of instruction).
- 110 CALL and 111 RET: see Configuration.

Stall and fault:
- stall = 1: upc, stack, counter and fault all hold; next_sel is ignored.
- fault = 1: upc is forced to 0 and held; ir_load stays 0; cleared only by rst.
- Reset mid-instruction abandons the instruction and restarts at fetch.

## Timing
- Single cycle per microinstruction. next_sel and branch_addr are combinational ROM outputs of the current upc, settled before the next rising edge.
- map_addr is sampled only on the DISPATCH edge and must be stable there.
- The map stage captures IR on a rising edge and updates its output on the falling edge. The microprogram therefore places DISPATCH at least 2 cycles after the ir_load cycle; the sequencer does not check this.
- Stall and fault precedence: stall has priority over next_sel; fault has priority over stall for the upc value.
- No combinational path from map_addr to any output.

## Configuration
Macro: USEQ_CALL_EN.

Defined (one-entry return stack):
- CALL: pushes upc+1 and sets upc ← branch_addr. CALL while the stack is full sets fault.
- RET: upc ← the stored address and the stack empties. RET while the stack is empty sets fault.

Undefined:
- No stack storage.
- 110 and 111 behave exactly as INC.

## Structure
- Shared package useq_pkg holds:
  - UPC_W default
  - FETCH_ADDR = 0, WAIT_ADDR = 1, MIN_DISPATCH = 2
  - next_sel localparams: SEL_INC, SEL_DISPATCH, SEL_JUMP, SEL_JZ, SEL_JNZ, SEL_FETCH, SEL_CALL, SEL_RET
- One sub-module is natural: useq_ret_stack.
  - One-entry register with valid flag, push/pop inputs, and overflow/underflow outputs.
  - Instantiated only under USEQ_CALL_EN.

## Test plan
- Reset, then INC, INC, DISPATCH with map_addr=5'b00100 → upc sequence 0,1,2,4; ir_load=1 only in the first cycle; dispatch_cnt=1.
- upc=31 with INC → upc=0 and ir_load=1 in the following cycle.
- JZ with branch_addr=10, first with z_flag=0 then z_flag=1 → upc=cur+1, then upc=10; repeat with JNZ → mirrored results.
- DISPATCH with map_addr=1 → fault=1 and upc=0 held for 10 cycles under any next_sel; ir_load=0; rst clears fault.
- stall=1 for 3 cycles during JUMP to 20 → upc and dispatch_cnt unchanged; jump takes effect on the first unstalled edge.
- With USEQ_CALL_EN: CALL to 24 from upc=7, then RET → upc=24, then upc=8. A second CALL without RET → fault=1. Without the macro, CALL → upc=8.

Source files
------------

// File: rtl/useq_pkg.sv
// Shared constants for the micro_sequencer block: address map and next-address select codes.
// The optional call/return stack is enabled with the USEQ_CALL_EN macro.
package useq_pkg;

    localparam int unsigned UPC_W_DEFAULT = 5;

    localparam int unsigned FETCH_ADDR   = 0;
    localparam int unsigned WAIT_ADDR    = 1;
    localparam int unsigned MIN_DISPATCH = 2;

    localparam logic [2:0] SEL_INC      = 3'b000;
    localparam logic [2:0] SEL_DISPATCH = 3'b001;
    localparam logic [2:0] SEL_JUMP     = 3'b010;
    localparam logic [2:0] SEL_JZ       = 3'b011;
    localparam logic [2:0] SEL_JNZ      = 3'b100;
    localparam logic [2:0] SEL_FETCH    = 3'b101;
    localparam logic [2:0] SEL_CALL     = 3'b110;
    localparam logic [2:0] SEL_RET      = 3'b111;

endpackage

// File: rtl/useq_ret_stack.sv
// One-entry microcode return stack with valid flag; reports push-when-full and pop-when-empty.
// Only instantiated when USEQ_CALL_EN is defined.
module useq_ret_stack #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_addr,
    output logic [W-1:0] top_addr,
    output logic         valid,
    output logic         overflow,
    output logic         underflow
);

    logic [W-1:0] addr_q;

    assign top_addr  = addr_q;
    assign overflow  = push && valid;
    assign underflow = pop && !valid;

    // Erroneous requests leave the entry untouched; the sequencer faults instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            valid  <= 1'b0;
        end else if (push && !valid) begin
            addr_q <= push_addr;
            valid  <= 1'b1;
        end else if (pop && valid) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram counter and next-address logic for the control store, with dispatch counting
// and a sticky sequencing fault. Define USEQ_CALL_EN to add the one-entry CALL/RET stack.
module micro_sequencer
    import useq_pkg::*;
#(
    parameter int unsigned UPC_W = UPC_W_DEFAULT,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [UPC_W-1:0] map_addr,
    input  logic [2:0]       next_sel,
    input  logic [UPC_W-1:0] branch_addr,
    input  logic             z_flag,
    input  logic             stall,
    output logic [UPC_W-1:0] upc,
    output logic             ir_load,
    output logic             fault,
    output logic [CNT_W-1:0] dispatch_cnt
);

    localparam logic [UPC_W-1:0] FETCH_UPC = UPC_W'(FETCH_ADDR);
    localparam logic [UPC_W-1:0] MIN_UPC   = UPC_W'(MIN_DISPATCH);

    logic             active;
    logic [UPC_W-1:0] upc_inc;
    logic [UPC_W-1:0] upc_d;
    logic             fault_d;
    logic [CNT_W-1:0] cnt_d;

    assign active  = !stall && !fault;
    assign upc_inc = upc + UPC_W'(1);
    assign ir_load = (upc == FETCH_UPC) && !stall && !fault;

`ifdef USEQ_CALL_EN
    logic             push_req;
    logic             pop_req;
    logic [UPC_W-1:0] stk_addr;
    logic             stk_valid;
    logic             stk_overflow;
    logic             stk_underflow;

    assign push_req = active && (next_sel == SEL_CALL);
    assign pop_req  = active && (next_sel == SEL_RET);

    useq_ret_stack #(
        .W (UPC_W)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .pop       (pop_req),
        .push_addr (upc_inc),
        .top_addr  (stk_addr),
        .valid     (stk_valid),
        .overflow  (stk_overflow),
        .underflow (stk_underflow)
    );
`endif

    always_comb begin
        upc_d   = upc;
        fault_d = fault;
        cnt_d   = dispatch_cnt;
        if (active) begin
            case (next_sel)
                SEL_DISPATCH: begin
                    // Words 0 and 1 belong to fetch; dispatching there means a bad map entry.
                    if (map_addr >= MIN_UPC) begin
                        upc_d = map_addr;
                        cnt_d = dispatch_cnt + CNT_W'(1);
                    end else begin
                        fault_d = 1'b1;
                        upc_d   = FETCH_UPC;
                    end
                end
                SEL_JUMP:  upc_d = branch_addr;
                SEL_JZ:    upc_d = z_flag ? branch_addr : upc_inc;
                SEL_JNZ:   upc_d = z_flag ? upc_inc : branch_addr;
                SEL_FETCH: upc_d = FETCH_UPC;
`ifdef USEQ_CALL_EN
                SEL_CALL: begin
                    if (stk_overflow) begin
                        fault_d = 1'b1;
                        upc_d   = FETCH_UPC;
                    end else begin
                        upc_d = branch_addr;
                    end
                end
                SEL_RET: begin
                    if (stk_underflow) begin
                        fault_d = 1'b1;
                        upc_d   = FETCH_UPC;
                    end else begin
                        upc_d = stk_addr;
                    end
                end
`endif
                default:   upc_d = upc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upc          <= FETCH_UPC;
            fault        <= 1'b0;
            dispatch_cnt <= '0;
        end else begin
            upc          <= upc_d;
            fault        <= fault_d;
            dispatch_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer; expectations follow USEQ_CALL_EN if defined.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  map_addr = '0;
    logic [2:0]  next_sel = '0;
    logic [4:0]  branch_addr = '0;
    logic        z_flag = 1'b0;
    logic        stall = 1'b0;
    logic [4:0]  upc;
    logic        ir_load;
    logic        fault;
    logic [15:0] dispatch_cnt;

    int checks = 0;
    int failures = 0;

    localparam logic [2:0] INC = 3'd0, DSP = 3'd1, JMP = 3'd2, JZ = 3'd3,
                           JNZ = 3'd4, FET = 3'd5, CAL = 3'd6, RET = 3'd7;

    micro_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .map_addr     (map_addr),
        .next_sel     (next_sel),
        .branch_addr  (branch_addr),
        .z_flag       (z_flag),
        .stall        (stall),
        .upc          (upc),
        .ir_load      (ir_load),
        .fault        (fault),
        .dispatch_cnt (dispatch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one microinstruction, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic [2:0] sel, input logic [4:0] b, input logic [4:0] m,
                       input logic z, input logic s);
        next_sel    = sel;
        branch_addr = b;
        map_addr    = m;
        z_flag      = z;
        stall       = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_sel = INC;
        stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_upc", 32'(upc), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_cnt", 32'(dispatch_cnt), 0);
        chk("rst_ir_load", 32'(ir_load), 1);

        cyc(INC, 0, 0, 0, 0);
        chk("inc1_upc", 32'(upc), 1);
        chk("inc1_ir_load", 32'(ir_load), 0);
        cyc(INC, 0, 0, 0, 0);
        chk("inc2_upc", 32'(upc), 2);
        cyc(DSP, 0, 5'b00100, 0, 0);
        chk("dsp_upc", 32'(upc), 4);
        chk("dsp_cnt", 32'(dispatch_cnt), 1);
        chk("dsp_ir_load", 32'(ir_load), 0);

        cyc(JMP, 31, 0, 0, 0);
        chk("jmp31_upc", 32'(upc), 31);
        cyc(INC, 0, 0, 0, 0);
        chk("wrap_upc", 32'(upc), 0);
        chk("wrap_ir_load", 32'(ir_load), 1);

        cyc(JMP, 3, 0, 0, 0);
        cyc(JZ, 10, 0, 0, 0);
        chk("jz_z0", 32'(upc), 4);
        cyc(JZ, 10, 0, 1, 0);
        chk("jz_z1", 32'(upc), 10);
        cyc(JNZ, 10, 0, 1, 0);
        chk("jnz_z1", 32'(upc), 11);
        cyc(JNZ, 10, 0, 0, 0);
        chk("jnz_z0", 32'(upc), 10);
        cyc(FET, 0, 0, 0, 0);
        chk("fetch_upc", 32'(upc), 0);

        for (int i = 0; i < 3; i++) begin
            cyc(JMP, 20, 0, 0, 1);
            chk("stall_upc", 32'(upc), 0);
            chk("stall_cnt", 32'(dispatch_cnt), 1);
            chk("stall_ir_load", 32'(ir_load), 0);
        end
        cyc(JMP, 20, 0, 0, 0);
        chk("unstall_jmp", 32'(upc), 20);
        cyc(DSP, 0, 9, 0, 1);
        chk("stall_dsp_upc", 32'(upc), 20);
        chk("stall_dsp_cnt", 32'(dispatch_cnt), 1);
        cyc(DSP, 0, 2, 0, 0);
        chk("dsp_min_upc", 32'(upc), 2);
        chk("dsp_min_fault", 32'(fault), 0);
        chk("dsp_min_cnt", 32'(dispatch_cnt), 2);

        cyc(JMP, 7, 0, 0, 0);
        cyc(CAL, 24, 0, 0, 0);
`ifdef USEQ_CALL_EN
        chk("call_upc", 32'(upc), 24);
        cyc(RET, 0, 0, 0, 0);
        chk("ret_upc", 32'(upc), 8);
        cyc(CAL, 24, 0, 0, 0);
        chk("call2_upc", 32'(upc), 24);
        cyc(CAL, 12, 0, 0, 0);
        chk("call_full_fault", 32'(fault), 1);
        chk("call_full_upc", 32'(upc), 0);
        do_reset();
        cyc(RET, 0, 0, 0, 0);
        chk("ret_empty_fault", 32'(fault), 1);
        do_reset();
`else
        chk("call_as_inc", 32'(upc), 8);
        cyc(RET, 0, 0, 0, 0);
        chk("ret_as_inc", 32'(upc), 9);
        chk("ret_no_fault", 32'(fault), 0);
`endif

        cyc(JMP, 6, 0, 0, 0);
        cyc(DSP, 0, 1, 0, 0);
        chk("dsp_bad_fault", 32'(fault), 1);
        chk("dsp_bad_upc", 32'(upc), 0);
        chk("dsp_bad_ir_load", 32'(ir_load), 0);
        for (int i = 0; i < 10; i++) begin
            cyc(3'(i), 5'(i + 5), 5'(i + 4), i[0], i[1]);
            chk("fault_hold_upc", 32'(upc), 0);
            chk("fault_hold_fault", 32'(fault), 1);
            chk("fault_hold_ir_load", 32'(ir_load), 0);
        end

        // Asynchronous reset must clear state without a clock edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_fault", 32'(fault), 0);
        chk("arst_upc", 32'(upc), 0);
        chk("arst_cnt", 32'(dispatch_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        #1;
        chk("arst_ir_load", 32'(ir_load), 1);
        cyc(INC, 0, 0, 0, 0);
        chk("post_rst_inc", 32'(upc), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
